// File: rtl/audio_pkg.sv
// Shared audio types and frame geometry for the I2S output path.
package audio_pkg;

   localparam int SAMPLE_W        = 32;
   localparam int SLOTS_PER_FRAME = 64;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Circular sample buffer between the synthesizer core and the I2S serializer.
module sample_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH = 16
)
(
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     push,
   input  logic                     pop,
   input  sample_t                  din,
   output sample_t                  dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);

   sample_t            mem [0:DEPTH-1];
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [PTR_W:0]     count_reg;
   logic               push_ok;
   logic               pop_ok;

   assign full    = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr_reg];
   assign level   = count_reg;

   always_ff @(posedge CLK) begin
      if (push_ok)
         mem[wr_ptr_reg] <= din;
   end

   // Pointers are exactly log2(DEPTH) wide, so they wrap without compare logic.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/i2s_audio_out.sv
// Mono master-mode I2S transmitter: FIFO-buffered samples, BCLK/LRCK generated from CLK.
module i2s_audio_out
   import audio_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int BCLK_HALF = 8
)
(
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     ENABLE,
   input  logic                     LD_FIFO,
   input  logic [SAMPLE_W-1:0]      TONE,
   output logic                     FIFO_FULL,
   output logic [$clog2(DEPTH):0]   LEVEL,
   output logic                     UNDERRUN,
   output logic                     OVERFLOW,
   output logic                     AUD_BCLK,
   output logic                     AUD_DACLRCK,
   output logic                     AUD_DACDAT
);

   localparam int          DIV_W     = $clog2(BCLK_HALF);
   localparam int          SLOT_W    = $clog2(SLOTS_PER_FRAME);
   localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(SLOTS_PER_FRAME - 1);
   localparam logic [SLOT_W-1:0] LEFT_MSB   = SLOT_W'(1);
   localparam logic [SLOT_W-1:0] RIGHT_MSB  = SLOT_W'(SLOTS_PER_FRAME / 2 + 1);

   logic [DIV_W-1:0]    div_cnt_reg;
   logic [SLOT_W-1:0]   slot_reg;
   logic [SLOT_W-1:0]   slot_next;
   sample_t             sample_reg;
   sample_t             shift_reg;
   sample_t             fifo_dout;
   logic                bclk_reg;
   logic                lrck_reg;
   logic                dat_reg;
   logic                underrun_reg;
   logic                overflow_reg;
   logic                div_wrap;
   logic                fe;
   logic                frame_start;
   logic                fifo_empty;
   logic                fifo_pop;

   sample_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK   (CLK),
      .RESET (RESET),
      .push  (LD_FIFO),
      .pop   (fifo_pop),
      .din   (sample_t'(TONE)),
      .dout  (fifo_dout),
      .level (LEVEL),
      .full  (FIFO_FULL),
      .empty (fifo_empty)
   );

   assign div_wrap    = (div_cnt_reg == DIV_W'(BCLK_HALF - 1));
   assign fe          = ENABLE && div_wrap && bclk_reg;
   assign slot_next   = slot_reg + 1'b1;
   assign frame_start = fe && (slot_reg == LAST_SLOT);
   assign fifo_pop    = frame_start && !fifo_empty;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         div_cnt_reg  <= '0;
         bclk_reg     <= 1'b0;
         slot_reg     <= LAST_SLOT;
         lrck_reg     <= 1'b0;
         dat_reg      <= 1'b0;
         shift_reg    <= '0;
         sample_reg   <= '0;
         underrun_reg <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         overflow_reg <= LD_FIFO && FIFO_FULL;
         underrun_reg <= frame_start && fifo_empty;
         if (!ENABLE) begin
            // Parked at slot 0 so the first falling edge after enable starts a left word.
            div_cnt_reg <= '0;
            bclk_reg    <= 1'b0;
            slot_reg    <= '0;
            lrck_reg    <= 1'b0;
            dat_reg     <= 1'b0;
            shift_reg   <= '0;
            sample_reg  <= '0;
         end else begin
            div_cnt_reg <= div_wrap ? '0 : div_cnt_reg + 1'b1;
            if (div_wrap)
               bclk_reg <= !bclk_reg;
            if (fe) begin
               slot_reg <= slot_next;
               lrck_reg <= slot_next[SLOT_W-1];
               if (frame_start)
                  sample_reg <= fifo_empty ? '0 : fifo_dout;
               // MSB goes out one BCLK after each LRCK edge; slots 0/32 carry the old LSB.
               if (slot_next == LEFT_MSB || slot_next == RIGHT_MSB) begin
                  shift_reg <= sample_reg;
                  dat_reg   <= sample_reg[SAMPLE_W-1];
               end else begin
                  shift_reg <= shift_reg << 1;
                  dat_reg   <= shift_reg[SAMPLE_W-2];
               end
            end
         end
      end
   end

   assign UNDERRUN    = underrun_reg;
   assign OVERFLOW    = overflow_reg;
   assign AUD_BCLK    = bclk_reg;
   assign AUD_DACLRCK = lrck_reg;
   assign AUD_DACDAT  = dat_reg;

endmodule

// File: tb/tb_i2s_audio_out.sv
// Cycle-by-cycle check of i2s_audio_out against a frame-arithmetic reference model.
module tb_i2s_audio_out;

   localparam int DEPTH = 16;
   localparam int HALF  = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          ENABLE = 1'b1;
   logic          LD_FIFO = 1'b0;
   logic [31:0]   TONE = '0;
   logic          FIFO_FULL;
   logic [LW-1:0] LEVEL;
   logic          UNDERRUN, OVERFLOW, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT;

   i2s_audio_out #(.DEPTH(DEPTH), .BCLK_HALF(HALF)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .ENABLE      (ENABLE),
      .LD_FIFO     (LD_FIFO),
      .TONE        (TONE),
      .FIFO_FULL   (FIFO_FULL),
      .LEVEL       (LEVEL),
      .UNDERRUN    (UNDERRUN),
      .OVERFLOW    (OVERFLOW),
      .AUD_BCLK    (AUD_BCLK),
      .AUD_DACLRCK (AUD_DACLRCK),
      .AUD_DACDAT  (AUD_DACDAT)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: n = CLK edges since the divider was last parked, b = slot at n = 0.
   int          n = 0;
   int          b = 63;
   logic [31:0] q[$];
   logic [31:0] cur_w = '0;
   logic [31:0] prev_w = '0;
   logic        exp_under = 1'b0;
   logic        exp_over = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic int slot_at(input int nn);
      return (b + nn / (2 * HALF)) % 64;
   endfunction

   function automatic bit next_is_fs();
      return !RESET && ENABLE && ((n + 1) % (2 * HALF) == 0) && (slot_at(n + 1) == 0);
   endfunction

   task automatic model_step();
      int sz;
      bit fs;
      sz = q.size();
      fs = 1'b0;
      if (RESET) begin
         n = 0; b = 63; q.delete();
         cur_w = '0; prev_w = '0; exp_under = 1'b0; exp_over = 1'b0;
      end else begin
         exp_over = LD_FIFO && (sz == DEPTH);
         if (!ENABLE) begin
            n = 0; b = 0; cur_w = '0;
         end else begin
            n++;
            if (n % (2 * HALF) == 0 && slot_at(n) == 0)
               fs = 1'b1;
         end
         exp_under = fs && (sz == 0);
         if (fs) begin
            prev_w = cur_w;
            cur_w  = (sz > 0) ? q.pop_front() : 32'h0;
         end
         if (LD_FIFO && sz < DEPTH)
            q.push_back(TONE);
      end
   endtask

   task automatic check_all();
      int s;
      logic e_lr, e_dat;
      s = slot_at(n);
      e_lr  = (n < 2 * HALF) ? 1'b0 : s[5];
      if (n < 2 * HALF)
         e_dat = 1'b0;
      else if (s == 0)
         e_dat = prev_w[0];
      else if (s <= 32)
         e_dat = cur_w[32 - s];
      else
         e_dat = cur_w[64 - s];
      chk("level", 32'(LEVEL), 32'(q.size()));
      chk("full", 32'(FIFO_FULL), 32'(q.size() == DEPTH));
      chk("underrun", 32'(UNDERRUN), 32'(exp_under));
      chk("overflow", 32'(OVERFLOW), 32'(exp_over));
      chk("bclk", 32'(AUD_BCLK), 32'((n / HALF) % 2));
      chk("lrck", 32'(AUD_DACLRCK), 32'(e_lr));
      chk("dat", 32'(AUD_DACDAT), 32'(e_dat));
   endtask

   task automatic tick();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      cyc++;
      check_all();
   endtask

   task automatic wait_fs();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         if (next_is_fs()) found = 1'b1;
         else tick();
      end
      chk("fs_found", 32'(found), 32'd1);
   endtask

   task automatic wait_slot(input int target);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         if (n > 0 && slot_at(n) == target) found = 1'b1;
         else tick();
      end
      chk("slot_found", 32'(found), 32'd1);
   endtask

   initial begin
      // Single sample pushed before the first frame start, then underruns.
      RESET = 1'b1; ENABLE = 1'b1;
      repeat (3) tick();
      RESET = 1'b0;
      LD_FIFO = 1'b1; TONE = 32'hA5A5_0F0F;
      tick();
      LD_FIFO = 1'b0;
      repeat (4200) tick();

      // Disabled: fill to full and overflow with push 17.
      ENABLE = 1'b0;
      for (int i = 0; i < 17; i++) begin
         LD_FIFO = 1'b1; TONE = $urandom();
         tick();
      end
      LD_FIFO = 1'b0;
      repeat (4) tick();

      // Level 3, then push exactly on the frame-start cycle.
      RESET = 1'b1;
      repeat (2) tick();
      RESET = 1'b0;
      for (int i = 0; i < 3; i++) begin
         LD_FIFO = 1'b1; TONE = $urandom();
         tick();
      end
      LD_FIFO = 1'b0;
      ENABLE = 1'b1;
      tick();
      wait_fs();
      LD_FIFO = 1'b1; TONE = $urandom();
      tick();
      LD_FIFO = 1'b0;

      // Level 5, reset at slot 20, then an underrunning frame start.
      for (int i = 0; i < 2; i++) begin
         LD_FIFO = 1'b1; TONE = $urandom();
         tick();
      end
      LD_FIFO = 1'b0;
      wait_slot(20);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      repeat (1100) tick();

      // Random traffic with occasional bursts and enable drops.
      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(0, 2999) == 0) ENABLE = !ENABLE;
         if ($urandom_range(0, 4999) == 0) begin
            for (int k = 0; k < 20; k++) begin
               LD_FIFO = 1'b1; TONE = $urandom();
               tick();
            end
         end
         LD_FIFO = ($urandom_range(0, 599) < 2);
         TONE = $urandom();
         tick();
      end
      LD_FIFO = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2s_audio_out.md
# i2s_audio_out

Audio output stage directly downstream of the synthesizer core. It buffers the 32-bit mixed tone words that the core pushes with `LD_FIFO`/`TONE` in a small sample FIFO and returns `FIFO_FULL` as back-pressure. It serializes one sample per audio frame to the board codec as master-mode I2S, sending the same sample on both channels (mono). It generates the codec bit clock and LR clock itself from `CLK`.

## Interface
- `DEPTH`, 16, FIFO depth in words; power of two, ≥ 2.
- `BCLK_HALF`, 8, `CLK` cycles per BCLK half-period; ≥ 2. At 50 MHz this gives BCLK = 3.125 MHz and fs = 48.83 kHz.

- `CLK`  in  1  system clock; reset is `RESET`, synchronous, active-high, on clock `CLK`.
- `RESET`  in  1  synchronous active-high reset.
- `ENABLE`  in  1  run the serializer. The FIFO operates regardless of `ENABLE`.
- `LD_FIFO`  in  1  push `TONE` this cycle.
- `TONE`  in  32  signed sample word.
- `FIFO_FULL`  out  1  count == `DEPTH`.
- `LEVEL`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `UNDERRUN`  out  1  one-`CLK` pulse when a frame starts with the FIFO empty.
- `OVERFLOW`  out  1  one-`CLK` pulse when a push is dropped because the FIFO is full.
- `AUD_BCLK`  out  1  I2S bit clock.
- `AUD_DACLRCK`  out  1  LR clock; 0 = left, 1 = right.
- `AUD_DACDAT`  out  1  serial data, MSB first.

## Operation
- **FIFO**
  - Push is accepted when `LD_FIFO && !FIFO_FULL`.
  - When `LD_FIFO && FIFO_FULL`, the word is dropped, `OVERFLOW` pulses, and FIFO contents are unchanged.
  - Pops are issued only by the serializer.
  - Push and pop in the same cycle: both happen and `LEVEL` is unchanged. A push into a full FIFO is still dropped in that cycle, even when a pop also occurs.
  - `FIFO_FULL` and `LEVEL` are decoded from the registered count, so they update on the cycle after the push/pop edge.
- **Clock divider**
  - `div_cnt` counts 0..`BCLK_HALF`-1. At wrap, `AUD_BCLK` toggles.
  - A toggle from 1 to 0 is a falling-edge event (`fe`).
- **Slot counter**
  - `slot` is 6 bits, 0..63, and increments on each `fe`, wrapping 63→0.
  - `AUD_DACLRCK` is set to `slot[5]` at each `fe`.
- **Frame start** (an `fe` where `slot` goes 63→0):
  - If the FIFO is non-empty, pop the head into `sample_reg`.
  - If the FIFO is empty, load 0 into `sample_reg` and pulse `UNDERRUN`.
- **Data**
  - At an `fe` entering slot 1 or slot 33: `shift_reg` ← `sample_reg` and `AUD_DACDAT` ← `sample_reg[31]`.
  - At any other `fe`: shift left and output the next bit.
  - This places the MSB one BCLK after each LRCK edge (standard I2S). The bit in slots 0 and 32 is the previous word's LSB.
  - Right channel = left channel = `sample_reg`.
- **`ENABLE` low**
  - `div_cnt`, `slot` and `shift_reg` are held at 0.
  - `AUD_BCLK`, `AUD_DACLRCK` and `AUD_DACDAT` are 0.
  - No pops occur.
  - When `ENABLE` rises, the first `fe` enters slot 1 of a frame with `sample_reg` = 0. The first pop happens at the next 63→0 wrap.
- **Reset values**
  - FIFO empty: `LEVEL` = 0, `FIFO_FULL` = 0.
  - `AUD_BCLK`, `AUD_DACLRCK`, `AUD_DACDAT`, `UNDERRUN` and `OVERFLOW` are 0.
  - `slot` = 63 and `div_cnt` = 0. With `slot` = 63, the first `fe` after reset is a frame start.
  - `sample_reg` = 0.
  - Reset mid-frame discards FIFO contents and the partial word.

## Timing
- Push to `LEVEL`/`FIFO_FULL` update: 1 `CLK`.
- BCLK period = 2·`BCLK_HALF` `CLK` cycles; one frame = 64 BCLK = 128·`BCLK_HALF` `CLK` cycles.
- Pop, `UNDERRUN` pulse and the `slot` wrap occur in the same `CLK` cycle as the `fe` event.
- All outputs are registered; `AUD_DACDAT` and `AUD_DACLRCK` change only on `fe` cycles.
- Pushed word to its MSB on `AUD_DACDAT` (FIFO was empty, push lands before a frame start): MSB appears 1 BCLK after that frame start.

## Structure
- Package `audio_pkg`:
  - `SAMPLE_W` = 32
  - `SLOTS_PER_FRAME` = 64
  - typedef `sample_t` = logic signed [31:0]
- Sub-module `sample_fifo`: circular buffer with parameter `DEPTH`.
  - Ports: `push`, `pop`, `din`, `dout`, `level`, `full`, `empty`.
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally.
  - `dout` is the head word, combinationally valid while not empty.
- The top level contains the divider, slot counter, `sample_reg`, shift register and pulse generation.

## Test plan
- **Single sample.** After reset, `ENABLE`=1, push `TONE`=32'hA5A5_0F0F before the first frame start.
  - Bits on `AUD_DACDAT` at slots 1..32 read A5A50F0F MSB-first; slots 33..64 read the same word again.
  - `UNDERRUN` stays 0 for that frame.
- **Underrun.** No pushes, `ENABLE`=1.
  - `UNDERRUN` pulses once per frame (every 1024 `CLK` at `BCLK_HALF`=8).
  - `AUD_DACDAT` stays 0 throughout.
- **Full and overflow.** `ENABLE`=0, push 17 words with `DEPTH`=16.
  - `FIFO_FULL`=1 the cycle after push 16, and `LEVEL`=16.
  - Push 17 pulses `OVERFLOW`, and the FIFO contents are unchanged.
- **Simultaneous push and pop.** `LEVEL`=3, push on the exact frame-start cycle.
  - `LEVEL` stays 3, and the popped word is the oldest.
- **Clock geometry.** Measure `AUD_BCLK` and `AUD_DACLRCK`.
  - BCLK period = 16 `CLK`.
  - LRCK toggles every 32 BCLK falling edges.
  - MSB lags each LRCK edge by exactly 1 BCLK.
- **Reset mid-frame.** Assert `RESET` at slot 20 with `LEVEL`=5.
  - Next cycle: all outputs 0, `LEVEL`=0.
  - The first `fe` after release is a frame start that underruns.
